// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end of the 5-stage MIPS pipeline.
// Owns the PC, issues word reads to the icache and loads the FD latch.
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   ihit, iload        icache response (valid strobe, instruction word)
//   iREN, iaddr        icache request (read enable, word address = PC)
//   FDen, FDflush      FD latch control from the hazard unit
//   halt               stop fetching until reset
//   branch_taken/target, jump_valid/target   PC redirects (single-cycle pulses)
//   fd_valid, fd_instr, fd_pc4               FD latch contents
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        FDen,
   input  logic        FDflush,
   input  logic        halt,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   output logic        fd_valid,
   output logic [31:0] fd_instr,
   output logic [31:0] fd_pc4
);

   typedef enum logic [1:0] {RUN = 2'd0, RWAIT = 2'd1, HALTED = 2'd2} state_t;

   state_t      r_state, w_state_nx;
   logic [31:0] r_pc, w_pc_nx;
   logic [31:0] r_pend, w_pend_nx;
   logic        r_fd_valid, w_fd_valid_nx;
   logic [31:0] r_fd_instr, w_fd_instr_nx;
   logic [31:0] r_fd_pc4, w_fd_pc4_nx;

   logic        w_redir;
   logic [31:0] w_tgt;
   logic [31:0] w_pc4;

   // Branch is the older instruction, so it wins over a same-cycle jump.
   assign w_redir = branch_taken | jump_valid;
   assign w_tgt   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
   assign w_pc4   = r_pc + 32'd4;

   assign iREN  = (r_state != HALTED);
   assign iaddr = r_pc;

   assign fd_valid = r_fd_valid;
   assign fd_instr = r_fd_instr;
   assign fd_pc4   = r_fd_pc4;

   always_comb begin
      w_state_nx    = r_state;
      w_pc_nx       = r_pc;
      w_pend_nx     = r_pend;
      w_fd_valid_nx = r_fd_valid;
      w_fd_instr_nx = r_fd_instr;
      w_fd_pc4_nx   = r_fd_pc4;

      if (halt) begin
         w_state_nx    = HALTED;
         w_pend_nx     = 32'h0;
         w_fd_valid_nx = 1'b0;
         w_fd_instr_nx = 32'h0;
         w_fd_pc4_nx   = 32'h0;
      end else begin
         case (r_state)
            RUN: begin
               if (ihit) begin
                  if (w_redir) begin
                     // Word just fetched is wrong-path: drop it.
                     w_fd_valid_nx = 1'b0;
                     w_fd_instr_nx = 32'h0;
                     w_fd_pc4_nx   = 32'h0;
                     w_pc_nx       = w_tgt;
                  end else if (FDen) begin
                     w_fd_valid_nx = 1'b1;
                     w_fd_instr_nx = iload;
                     w_fd_pc4_nx   = w_pc4;
                     w_pc_nx       = w_pc4;
                  end
               end else if (w_redir) begin
                  // Keep iaddr stable until the in-flight read completes.
                  w_pend_nx  = w_tgt;
                  w_state_nx = RWAIT;
               end
            end
            RWAIT: begin
               if (ihit) begin
                  w_fd_valid_nx = 1'b0;
                  w_fd_instr_nx = 32'h0;
                  w_fd_pc4_nx   = 32'h0;
                  w_pc_nx       = w_redir ? w_tgt : r_pend;
                  w_state_nx    = RUN;
               end else if (w_redir) begin
                  w_pend_nx = w_tgt;
               end
            end
            default: ;  // HALTED: frozen until reset
         endcase
      end

      if (FDflush) begin
         w_fd_valid_nx = 1'b0;
         w_fd_instr_nx = 32'h0;
         w_fd_pc4_nx   = 32'h0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= RUN;
         r_pc       <= PC_INIT;
         r_pend     <= 32'h0;
         r_fd_valid <= 1'b0;
         r_fd_instr <= 32'h0;
         r_fd_pc4   <= 32'h0;
      end else begin
         r_state    <= w_state_nx;
         r_pc       <= w_pc_nx;
         r_pend     <= w_pend_nx;
         r_fd_valid <= w_fd_valid_nx;
         r_fd_instr <= w_fd_instr_nx;
         r_fd_pc4   <= w_fd_pc4_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, sequential fetch, stall,
// redirect under miss, branch/jump priority, flush, halt and PC wrap.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] iload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        FDen, FDflush, halt;
   logic        branch_taken, jump_valid;
   logic [31:0] branch_target, jump_target;
   logic        fd_valid;
   logic [31:0] fd_instr, fd_pc4;

   int n_chk  = 0;
   int n_pass = 0;

   fetch_unit #(.PC_INIT(32'h0)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload),
      .iREN(iREN), .iaddr(iaddr), .FDen(FDen), .FDflush(FDflush),
      .halt(halt), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_pc4(fd_pc4)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; iload = 32'h0; FDen = 1'b1; FDflush = 1'b0;
      halt = 1'b0; branch_taken = 1'b0; jump_valid = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0;
      step(); step();
      chk("rst_iren", {31'h0, iREN}, 32'd1);
      chk("rst_iaddr", iaddr, 32'h0);
      chk("rst_fdvalid", {31'h0, fd_valid}, 32'd0);
      chk("rst_fdinstr", fd_instr, 32'h0);
      RST = 1'b0;

      // Sequential fetch A,B,C,D
      ihit = 1'b1; FDen = 1'b1;
      iload = 32'hAAAA_0001; chk("seq_a_addr", iaddr, 32'h0); step();
      chk("seq_a_instr", fd_instr, 32'hAAAA_0001);
      chk("seq_a_pc4", fd_pc4, 32'h4);
      chk("seq_a_valid", {31'h0, fd_valid}, 32'd1);
      chk("seq_b_addr", iaddr, 32'h4);
      iload = 32'hBBBB_0002; step();
      chk("seq_b_instr", fd_instr, 32'hBBBB_0002);
      chk("seq_b_pc4", fd_pc4, 32'h8);
      chk("seq_c_addr", iaddr, 32'h8);
      iload = 32'hCCCC_0003; step();
      chk("seq_c_instr", fd_instr, 32'hCCCC_0003);
      chk("seq_c_pc4", fd_pc4, 32'hC);
      iload = 32'hDDDD_0004; step();
      chk("seq_d_pc4", fd_pc4, 32'h10);
      chk("seq_d_addr", iaddr, 32'h10);

      // Stall at 0x10
      FDen = 1'b0; iload = 32'hEEEE_0005;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_addr", iaddr, 32'h10);
         chk("stall_instr", fd_instr, 32'hDDDD_0004);
         chk("stall_pc4", fd_pc4, 32'h10);
      end
      FDen = 1'b1; step();
      chk("unstall_instr", fd_instr, 32'hEEEE_0005);
      chk("unstall_pc4", fd_pc4, 32'h14);
      chk("unstall_addr", iaddr, 32'h14);

      // Walk to 0x20
      iload = 32'h1111_1111; step(); step(); step();
      chk("walk_addr", iaddr, 32'h20);

      // Redirect with miss: jump to 0x103 while fetch at 0x20 is pending
      ihit = 1'b0; jump_valid = 1'b1; jump_target = 32'h103; step();
      jump_valid = 1'b0;
      chk("rw_addr0", iaddr, 32'h20);
      chk("rw_valid0", {31'h0, fd_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rw_addr", iaddr, 32'h20);
         chk("rw_iren", {31'h0, iREN}, 32'd1);
      end
      ihit = 1'b1; step();
      chk("rw_done_valid", {31'h0, fd_valid}, 32'd0);
      chk("rw_done_addr", iaddr, 32'h100);

      // Branch and jump together with hit: branch wins
      branch_taken = 1'b1; branch_target = 32'h40;
      jump_valid = 1'b1; jump_target = 32'h80; step();
      branch_taken = 1'b0; jump_valid = 1'b0;
      chk("prio_addr", iaddr, 32'h40);
      chk("prio_valid", {31'h0, fd_valid}, 32'd0);
      chk("prio_instr", fd_instr, 32'h0);
      iload = 32'hF00D_0006; step();
      chk("post_instr", fd_instr, 32'hF00D_0006);
      chk("post_pc4", fd_pc4, 32'h44);
      // Flush beats FDen; PC still advances
      FDflush = 1'b1; iload = 32'h2222_2222; step();
      FDflush = 1'b0;
      chk("flush_valid", {31'h0, fd_valid}, 32'd0);
      chk("flush_instr", fd_instr, 32'h0);
      chk("flush_pc4", fd_pc4, 32'h0);
      chk("flush_addr", iaddr, 32'h48);

      // Halt while in RWAIT with pending 0x200
      ihit = 1'b0; branch_taken = 1'b1; branch_target = 32'h200; step();
      branch_taken = 1'b0;
      chk("hrw_addr", iaddr, 32'h48);
      halt = 1'b1; step();
      halt = 1'b0;
      chk("halt_iren", {31'h0, iREN}, 32'd0);
      chk("halt_addr", iaddr, 32'h48);
      chk("halt_valid", {31'h0, fd_valid}, 32'd0);
      ihit = 1'b1; jump_valid = 1'b1; jump_target = 32'h300; step();
      jump_valid = 1'b0; step();
      chk("halted_iren", {31'h0, iREN}, 32'd0);
      chk("halted_addr", iaddr, 32'h48);

      // Asynchronous reset pulse mid-cycle
      RST = 1'b1; #1;
      chk("rst2_addr", iaddr, 32'h0);
      chk("rst2_iren", {31'h0, iREN}, 32'd1);
      step();
      RST = 1'b0;

      // Wrap: branch to 0xFFFF_FFFC then fetch
      ihit = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF; step();
      branch_taken = 1'b0;
      chk("wrap_addr0", iaddr, 32'hFFFF_FFFC);
      iload = 32'h3333_0007; step();
      chk("wrap_instr", fd_instr, 32'h3333_0007);
      chk("wrap_pc4", fd_pc4, 32'h0);
      chk("wrap_addr1", iaddr, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the 5-stage MIPS pipeline: owns the PC, issues word reads to the instruction cache and loads the fetch/decode pipeline latch. It sits directly upstream of the hazard unit's FD control and consumes its `FDen`/`FDflush` outputs. It also accepts PC redirects from the decode stage (jumps) and the execute stage (branches). It stops fetching permanently on `halt`.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset; low 2 bits must be 0.
- `CLK`  in  1  pipeline clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ihit`  in  1  icache returns valid `iload` this cycle.
- `iload`  in  32  instruction word from icache.
- `iREN`  out  1  instruction read request.
- `iaddr`  out  32  instruction read address (= PC).
- `FDen`  in  1  from hazard unit; FD latch may advance.
- `FDflush`  in  1  from hazard unit; FD latch becomes a bubble.
- `halt`  in  1  halt retired; stop fetching.
- `branch_taken`  in  1  execute-stage taken branch, single-cycle pulse.
- `branch_target`  in  32  branch destination.
- `jump_valid`  in  1  decode-stage jump (j/jal/jr), single-cycle pulse.
- `jump_target`  in  32  jump destination.
- `fd_valid`  out  1  FD latch holds a real instruction.
- `fd_instr`  out  32  latched instruction; 32'h0 (sll nop) when bubble.
- `fd_pc4`  out  32  latched PC+4 of that instruction.

## Operation
- Three states:
  - RUN: normal fetch.
  - RWAIT: redirect pending while a fetch is in flight.
  - HALTED: fetch stopped.
- Redirect selection:
  - redirect = `branch_taken` | `jump_valid`.
  - If both are asserted, `branch_target` wins, because the branch is the older instruction.
  - The low 2 bits of any target are forced to 0.
- `iREN` = 1 in RUN and RWAIT, 0 in HALTED.
- `iaddr` = PC in every state. The PC changes only on the clock edge where the current fetch completes (`ihit`=1), so the address stays stable for the whole request.
- RUN behaviour:
  - `ihit`=1, no redirect, `FDen`=1: FD latch ← {1, `iload`, PC+4}; PC ← PC+4.
  - `ihit`=1, no redirect, `FDen`=0: FD latch holds; PC holds. The same word is refetched.
  - `ihit`=1 with redirect: fetched word is wrong-path and discarded. FD latch ← bubble; PC ← target; stay in RUN.
  - `ihit`=0 with redirect: target captured in a pending register; → RWAIT; PC holds.
  - `ihit`=0, no redirect: nothing changes.
- RWAIT behaviour:
  - A new redirect overwrites the pending target, using the same priority rules.
  - On `ihit`: the word is discarded, FD latch ← bubble, PC ← pending target (or the new redirect target if one arrives in the same cycle); → RUN.
- `FDflush`:
  - Forces FD latch ← {0, 32'h0, 32'h0} on that edge, regardless of `FDen`/`ihit`.
  - Has no effect on the PC.
- `halt`:
  - Highest priority: → HALTED on the next edge from any state.
  - Pending redirect is dropped and PC is frozen.
  - FD latch ← bubble.
  - HALTED is left only via `RST`.
- Arithmetic: PC+4 is unsigned 32-bit with wrap-around; 32'hFFFF_FFFC + 4 = 32'h0.

## Timing
- Reset values (asynchronous, while `RST`=1):
  - PC = `PC_INIT`, state = RUN.
  - `fd_valid` = 0, `fd_instr` = 0, `fd_pc4` = 0, pending target = 0.
  - Hence `iREN` = 1 and `iaddr` = `PC_INIT`.
- Reset mid-fetch abandons the request; the first fetch after reset deassertion is at `PC_INIT`.
- Fetch latency: `ihit` at edge N puts the instruction on the FD outputs after edge N; `iaddr` shows PC+4 in cycle N+1.
- Redirect latency:
  - Pulse coincident with `ihit`: `iaddr` = target in the next cycle.
  - Otherwise: `iaddr` = target in the cycle after the in-flight fetch's `ihit`.
- Pulse rule: `branch_taken` and `jump_valid` are sampled only on the edge where they are high. Sources must not hold them more than one cycle per event.
- Outputs `iREN` and `iaddr` are combinational from registered state only.
- There is no combinational path from `ihit` to `iaddr`.

## Test plan
- Reset release with `PC_INIT`=0, `ihit`=1 every cycle, `FDen`=1, `iload`=A,B,C → `iaddr` 0,4,8; `fd_instr` A,B,C with `fd_pc4` 4,8,C, `fd_valid`=1 from the first edge after reset.
- Stall: `FDen`=0 for 3 cycles at PC=0x10 with `ihit`=1 → `iaddr` stays 0x10, FD outputs unchanged; `FDen`=1 → latches the 0x10 word, `fd_pc4`=0x14.
- Redirect with miss: at PC=0x20, `ihit`=0 for 4 cycles, `jump_valid` pulse with target 0x103 in cycle 1 → state RWAIT, `iaddr`=0x20 until `ihit`; after `ihit`, `fd_valid`=0 and `iaddr`=0x100.
- Simultaneous `branch_taken` (0x40) and `jump_valid` (0x80) with `ihit`=1 → `iaddr`=0x40, FD bubble; then `FDflush` with `FDen`=1, `ihit`=1 → `fd_valid`=0, `fd_instr`=0.
- `halt` while in RWAIT with pending 0x200 → `iREN`=0, `iaddr` frozen at current PC, `fd_valid`=0; later redirects and `ihit` are ignored; `RST` pulse → `iaddr`=`PC_INIT`, `iREN`=1.
- Wrap: PC=0xFFFF_FFFC, `ihit`=1, `FDen`=1 → `fd_pc4`=0, next `iaddr`=0.
